// File: rtl/uart_pkg.sv
// Shared encodings and character constants for the UART echo datapath.
package uart_pkg;

  typedef enum logic [1:0] {
    MODE_ECHO  = 2'b00,
    MODE_UPPER = 2'b01,
    MODE_LINE  = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_LOWER_A    = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z    = 8'h7A;
  localparam logic [7:0] ASCII_CASE_DELTA = 8'h20;

endpackage

// File: rtl/uart_echo_engine_fifo.sv
// Single-clock FIFO with extra-bit pointers exposed so the owner can build
// its own release logic on top of the raw storage.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic [WIDTH-1:0]         wdata_in,
  input  logic [$clog2(DEPTH)-1:0] raddr_in,
  output logic [WIDTH-1:0]         rdata_out,
  output logic [$clog2(DEPTH):0]   wr_ptr_out,
  output logic [$clog2(DEPTH):0]   rd_ptr_out,
  output logic [$clog2(DEPTH):0]   level_out,
  output logic                     full_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_DEPTH = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_in) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_in)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_in) mem_q[wr_ptr_q[AW-1:0]] <= wdata_in;
  end

  always_comb begin
    rdata_out  = mem_q[raddr_in];
    wr_ptr_out = wr_ptr_q;
    rd_ptr_out = rd_ptr_q;
    level_out  = wr_ptr_q - rd_ptr_q;
    full_out   = (level_out == PTR_DEPTH);
  end

endmodule

// File: rtl/uart_echo_engine.sv
// Echo datapath from a UART receiver to a transmitter: buffered, optionally
// upper-cased, optionally line-gated, with saturating overflow accounting.
module uart_echo_engine
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_BITS  = 16
) (
  input  logic                   sysclk,
  input  logic                   rst_in,
  input  logic [1:0]             mode_in,
  input  logic [DATA_BITS-1:0]   rx_data_in,
  input  logic                   rx_valid_in,
  output logic [DATA_BITS-1:0]   tx_data_out,
  output logic                   tx_valid_out,
  input  logic                   tx_ready_in,
  output logic [$clog2(DEPTH):0] fifo_level_out,
  output logic [CNT_BITS-1:0]    overflow_cnt_out,
  output logic                   drop_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
  localparam logic [AW:0] PTR_DEPTH = DEPTH;

  function automatic logic [DATA_BITS-1:0] upcase(input logic [DATA_BITS-1:0] c);
    logic [DATA_BITS-1:0] r;
    r = c;
    if (DATA_BITS == 8 &&
        c >= DATA_BITS'(ASCII_LOWER_A) && c <= DATA_BITS'(ASCII_LOWER_Z))
      r = c - DATA_BITS'(ASCII_CASE_DELTA);
    return r;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + CNT_BITS'(1);
  endfunction

  mode_e mode;

  logic                 push, pop, write_req, fifo_full;
  logic [DATA_BITS-1:0] wdata, rdata;
  logic [AW:0]          wr_ptr, rd_ptr, level;
  logic [AW:0]          wr_ptr_nxt, rd_ptr_nxt;

  logic [AW:0]          commit_q, commit_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 drop_q, drop_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  always_comb begin
    mode       = mode_e'(mode_in);
    pop        = tx_valid_q & tx_ready_in;
    write_req  = rx_valid_in & (mode != MODE_MUTE);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = write_req & (~fifo_full | pop);
    drop_d     = write_req & fifo_full & ~pop;
    wdata      = (mode == MODE_UPPER) ? upcase(rx_data_in) : rx_data_in;
    wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk        (sysclk),
    .rst        (rst_in),
    .push_in    (push),
    .pop_in     (pop),
    .wdata_in   (wdata),
    .raddr_in   (rd_ptr_nxt[AW-1:0]),
    .rdata_out  (rdata),
    .wr_ptr_out (wr_ptr),
    .rd_ptr_out (rd_ptr),
    .level_out  (level),
    .full_out   (fifo_full)
  );

  // Commit pointer: the release limit; only LINE mode lets it lag the writer.
  always_comb begin
    commit_d = commit_q;
    if (mode != MODE_LINE)
      commit_d = wr_ptr_nxt;
    else if (push && wdata == DATA_BITS'(ASCII_CR))
      commit_d = wr_ptr_nxt;
    else if ((wr_ptr_nxt - rd_ptr_nxt) == PTR_DEPTH)
      commit_d = wr_ptr_nxt;
  end

  // Output stage: registered view of the head entry. It compares against the
  // previous commit, so a fresh write reaches the output one edge later.
  always_comb begin
    tx_valid_d = (rd_ptr_nxt != commit_q);
    tx_data_d  = tx_valid_d ? rdata : tx_data_q;
    cnt_d      = drop_d ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge sysclk) begin
    if (rst_in) begin
      commit_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      commit_q   <= commit_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    tx_data_out      = tx_data_q;
    tx_valid_out     = tx_valid_q;
    fifo_level_out   = level;
    overflow_cnt_out = cnt_q;
    drop_out         = drop_q;
  end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine: reset, echo, uppercase, overflow,
// line gating and mute draining.
module tb_uart_echo_engine;
  import uart_pkg::*;

  logic       sysclk = 1'b0;
  logic       rst_in = 1'b1;
  logic [1:0] mode_in = 2'b00;
  logic [7:0] rx_data_in = 8'h00;
  logic       rx_valid_in = 1'b0;
  logic [7:0] tx_data_out;
  logic       tx_valid_out;
  logic       tx_ready_in = 1'b0;
  logic [4:0] fifo_level_out;
  logic [15:0] overflow_cnt_out;
  logic       drop_out;

  int n_cmp = 0;
  int n_bad = 0;
  int drops = 0;

  logic [7:0] up_in  [4] = '{8'h61, 8'h7A, 8'h7B, 8'h40};
  logic [7:0] up_out [4] = '{8'h41, 8'h5A, 8'h7B, 8'h40};

  uart_echo_engine #(
    .DATA_BITS (8),
    .DEPTH     (16),
    .CNT_BITS  (16)
  ) dut (
    .sysclk           (sysclk),
    .rst_in           (rst_in),
    .mode_in          (mode_in),
    .rx_data_in       (rx_data_in),
    .rx_valid_in      (rx_valid_in),
    .tx_data_out      (tx_data_out),
    .tx_valid_out     (tx_valid_out),
    .tx_ready_in      (tx_ready_in),
    .fifo_level_out   (fifo_level_out),
    .overflow_cnt_out (overflow_cnt_out),
    .drop_out         (drop_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    rx_valid_in = 1'b1;
    rx_data_in  = d;
    step();
    rx_valid_in = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    step();
    step();
    rst_in = 1'b0;
    chk("rst_valid", tx_valid_out, 0);
    chk("rst_level", fifo_level_out, 0);
    chk("rst_cnt", overflow_cnt_out, 0);
    chk("rst_drop", drop_out, 0);
    chk("rst_data", tx_data_out, 0);

    // Reset mid-stream
    mode_in = MODE_ECHO;
    tx_ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("mid_level", fifo_level_out, 5);
    chk("mid_valid", tx_valid_out, 1);
    chk("mid_data", tx_data_out, 8'h01);
    rst_in = 1'b1;
    rx_valid_in = 1'b1;
    rx_data_in = 8'h06;
    step();
    rst_in = 1'b0;
    rx_valid_in = 1'b0;
    chk("mid_rst_valid", tx_valid_out, 0);
    chk("mid_rst_level", fifo_level_out, 0);
    chk("mid_rst_cnt", overflow_cnt_out, 0);
    chk("mid_rst_data", tx_data_out, 0);
    step();
    chk("mid_rst_idle", tx_valid_out, 0);

    // ECHO latency and ordering
    tx_ready_in = 1'b1;
    rx_valid_in = 1'b1;
    rx_data_in = 8'h41;
    step();
    chk("echo_lat0", tx_valid_out, 0);
    rx_data_in = 8'h42;
    step();
    chk("echo_v1", tx_valid_out, 1);
    chk("echo_d1", tx_data_out, 8'h41);
    rx_data_in = 8'h43;
    step();
    chk("echo_d2", tx_data_out, 8'h42);
    rx_valid_in = 1'b0;
    step();
    chk("echo_v3", tx_valid_out, 1);
    chk("echo_d3", tx_data_out, 8'h43);
    step();
    chk("echo_end", tx_valid_out, 0);

    // UPPER transform
    mode_in = MODE_UPPER;
    for (int i = 0; i < 4; i++) begin
      rx_valid_in = 1'b1;
      rx_data_in = up_in[i];
      step();
      if (i > 0) chk("upper_d", tx_data_out, up_out[i-1]);
    end
    rx_valid_in = 1'b0;
    step();
    chk("upper_last", tx_data_out, up_out[3]);
    step();
    chk("upper_end", tx_valid_out, 0);

    // Overflow
    mode_in = MODE_ECHO;
    tx_ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      push(8'h10 + 8'(i));
      chk("ovf_drop", drop_out, (i >= 16) ? 1 : 0);
      if (drop_out) drops++;
    end
    step();
    chk("ovf_drop_idle", drop_out, 0);
    chk("ovf_pulses", drops, 4);
    chk("ovf_level", fifo_level_out, 16);
    chk("ovf_cnt", overflow_cnt_out, 4);
    chk("ovf_head", tx_data_out, 8'h10);
    tx_ready_in = 1'b1;
    push(8'hEE);
    chk("full_pp_level", fifo_level_out, 16);
    chk("full_pp_drop", drop_out, 0);
    chk("full_pp_cnt", overflow_cnt_out, 4);
    chk("full_pp_data", tx_data_out, 8'h11);
    for (int k = 2; k < 16; k++) begin
      step();
      chk("ovf_drain", tx_data_out, 8'h10 + 8'(k));
    end
    step();
    chk("ovf_tail", tx_data_out, 8'hEE);
    step();
    chk("ovf_empty_v", tx_valid_out, 0);
    chk("ovf_empty_l", fifo_level_out, 0);

    // LINE gating on CR
    mode_in = MODE_LINE;
    push(8'h68);
    chk("line_hold_h", tx_valid_out, 0);
    push(8'h69);
    chk("line_hold_i", tx_valid_out, 0);
    step();
    chk("line_hold_x", tx_valid_out, 0);
    chk("line_level", fifo_level_out, 2);
    push(8'h0D);
    chk("line_cr_lat", tx_valid_out, 0);
    step();
    chk("line_r0", tx_data_out, 8'h68);
    chk("line_r0v", tx_valid_out, 1);
    step();
    chk("line_r1", tx_data_out, 8'h69);
    step();
    chk("line_r2", tx_data_out, 8'h0D);
    step();
    chk("line_done", tx_valid_out, 0);

    // LINE full without CR commits everything
    for (int i = 0; i < 16; i++) begin
      push(8'h30 + 8'(i));
      chk("line_nocr_hold", tx_valid_out, 0);
    end
    chk("line_full_level", fifo_level_out, 16);
    step();
    chk("line_full_v", tx_valid_out, 1);
    chk("line_full_d0", tx_data_out, 8'h30);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("line_full_drain", tx_data_out, 8'h30 + 8'(k));
    end
    step();
    chk("line_full_end", tx_valid_out, 0);

    // Leaving LINE releases pending bytes
    push(8'h50);
    push(8'h51);
    chk("line_pend", tx_valid_out, 0);
    mode_in = MODE_ECHO;
    step();
    step();
    chk("leave_v", tx_valid_out, 1);
    chk("leave_d0", tx_data_out, 8'h50);
    step();
    chk("leave_d1", tx_data_out, 8'h51);
    step();
    chk("leave_end", tx_valid_out, 0);

    // MUTE discards silently, stored bytes still drain under stalls
    tx_ready_in = 1'b0;
    push(8'h71);
    push(8'h72);
    chk("mute_pre_level", fifo_level_out, 2);
    chk("mute_pre_data", tx_data_out, 8'h71);
    mode_in = MODE_MUTE;
    for (int i = 0; i < 3; i++) begin
      push(8'hA0 + 8'(i));
      chk("mute_level", fifo_level_out, 2);
      chk("mute_drop", drop_out, 0);
      chk("mute_cnt", overflow_cnt_out, 4);
      chk("mute_hold", tx_data_out, 8'h71);
    end
    step();
    chk("mute_stall_v", tx_valid_out, 1);
    chk("mute_stall_d", tx_data_out, 8'h71);
    tx_ready_in = 1'b1;
    step();
    tx_ready_in = 1'b0;
    chk("mute_pop_d", tx_data_out, 8'h72);
    chk("mute_pop_l", fifo_level_out, 1);
    step();
    step();
    chk("mute_stall2_v", tx_valid_out, 1);
    chk("mute_stall2_d", tx_data_out, 8'h72);
    tx_ready_in = 1'b1;
    step();
    chk("mute_end_v", tx_valid_out, 0);
    chk("mute_end_l", fifo_level_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
